// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a single-port, synchronous-read 64-bit word SRAM.
// Serves one burst at a time (FIXED/INCR, byte strobes, SLVERR on bad beats).
module axi_mem_slave #(
  parameter int unsigned DEPTH     = 65536,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  io_axi_mem_awid,
  input  logic [63:0] io_axi_mem_awaddr,
  input  logic [7:0]  io_axi_mem_awlen,
  input  logic [2:0]  io_axi_mem_awsize,
  input  logic [1:0]  io_axi_mem_awburst,
  input  logic        io_axi_mem_awlock,
  input  logic [3:0]  io_axi_mem_awcache,
  input  logic [2:0]  io_axi_mem_awprot,
  input  logic [3:0]  io_axi_mem_awqos,
  input  logic [3:0]  io_axi_mem_awregion,
  input  logic [3:0]  io_axi_mem_awuser,
  input  logic [5:0]  io_axi_mem_awatop,
  input  logic        io_axi_mem_awvalid,
  output logic        io_axi_mem_awready,
  input  logic [63:0] io_axi_mem_wdata,
  input  logic [7:0]  io_axi_mem_wstrb,
  input  logic        io_axi_mem_wlast,
  input  logic [3:0]  io_axi_mem_wuser,
  input  logic        io_axi_mem_wvalid,
  output logic        io_axi_mem_wready,
  output logic [3:0]  io_axi_mem_bid,
  output logic [1:0]  io_axi_mem_bresp,
  output logic [3:0]  io_axi_mem_buser,
  output logic        io_axi_mem_bvalid,
  input  logic        io_axi_mem_bready,
  input  logic [3:0]  io_axi_mem_arid,
  input  logic [63:0] io_axi_mem_araddr,
  input  logic [7:0]  io_axi_mem_arlen,
  input  logic [2:0]  io_axi_mem_arsize,
  input  logic [1:0]  io_axi_mem_arburst,
  input  logic        io_axi_mem_arlock,
  input  logic [3:0]  io_axi_mem_arcache,
  input  logic [2:0]  io_axi_mem_arprot,
  input  logic [3:0]  io_axi_mem_arqos,
  input  logic [3:0]  io_axi_mem_arregion,
  input  logic [3:0]  io_axi_mem_aruser,
  input  logic        io_axi_mem_arvalid,
  output logic        io_axi_mem_arready,
  output logic [3:0]  io_axi_mem_rid,
  output logic [63:0] io_axi_mem_rdata,
  output logic [1:0]  io_axi_mem_rresp,
  output logic        io_axi_mem_rlast,
  output logic [3:0]  io_axi_mem_ruser,
  output logic        io_axi_mem_rvalid,
  input  logic        io_axi_mem_rready,
  output logic [1:0]  dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // valid never waits on ready, and payload is held stable while valid && !ready.
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WRESP = 2'd2, READ = 2'd3} state_t;

  state_t      state;
  logic        prio_w;
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [7:0]  cnt;
  logic        bad_q;
  logic        err_q;
  logic        rerr_q;
  logic [63:0] mem_q;
  logic [63:0] mem [DEPTH];

  // Returns {in_range, word_index}; a carry out of bit 63 counts as out of range.
  function automatic logic [IW:0] beat_map(input logic [63:0] base, input logic [7:0] beat,
                                           input logic [2:0] size, input logic [1:0] burst);
    logic [64:0] sum;
    logic [63:0] off;
    logic        ok;
    sum = {1'b0, base} + ((burst == 2'b01) ? (65'(beat) << size) : 65'd0);
    off = sum[63:0] - BASE_ADDR;
    ok  = !sum[64] && (sum[63:0] >= BASE_ADDR) && ((off >> 3) < 64'(DEPTH));
    return {ok, off[IW+2:3]};
  endfunction

  logic          grant_w, grant_r;
  logic          w_ok, r_ok;
  logic [IW-1:0] w_idx, r_idx;
  logic          w_final, w_beat_err, mem_we, mem_re, r_bad;
  logic [7:0]    r_next;

  assign grant_w = io_axi_mem_awvalid && (!io_axi_mem_arvalid || prio_w);
  assign grant_r = io_axi_mem_arvalid && !grant_w;

  assign io_axi_mem_awready = (state == IDLE) && grant_w && !rst_i;
  assign io_axi_mem_arready = (state == IDLE) && grant_r && !rst_i;
  assign io_axi_mem_wready  = (state == WRITE);
  assign io_axi_mem_bvalid  = (state == WRESP);
  assign io_axi_mem_buser   = 4'd0;
  assign io_axi_mem_ruser   = 4'd0;
  assign io_axi_mem_rdata   = (io_axi_mem_rvalid && !rerr_q) ? mem_q : 64'd0;
  assign dbg_state          = state;

  assign {w_ok, w_idx} = beat_map(addr_q, cnt, size_q, burst_q);
  assign w_final       = (cnt == len_q);
  assign w_beat_err    = bad_q || !w_ok || (io_axi_mem_wlast != w_final);
  assign mem_we        = (state == WRITE) && io_axi_mem_wvalid && !bad_q && w_ok;

  // The read port looks at the AR channel in IDLE and at the next beat while bursting.
  assign r_next        = cnt + 8'd1;
  assign {r_ok, r_idx} = (state == IDLE)
                         ? beat_map(io_axi_mem_araddr, 8'd0, io_axi_mem_arsize, io_axi_mem_arburst)
                         : beat_map(addr_q, r_next, size_q, burst_q);
  assign r_bad         = (state == IDLE) ? io_axi_mem_arburst[1] : bad_q;
  assign mem_re        = (io_axi_mem_arvalid && io_axi_mem_arready) ||
                         ((state == READ) && io_axi_mem_rready && !io_axi_mem_rlast);

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (io_axi_mem_wstrb[b]) mem[w_idx][8*b +: 8] <= io_axi_mem_wdata[8*b +: 8];
      end
    end
    if (mem_re && !r_bad && r_ok) mem_q <= mem[r_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      prio_w            <= 1'b1;
      addr_q            <= 64'd0;
      len_q             <= 8'd0;
      size_q            <= 3'd0;
      burst_q           <= 2'd0;
      cnt               <= 8'd0;
      bad_q             <= 1'b0;
      err_q             <= 1'b0;
      rerr_q            <= 1'b0;
      io_axi_mem_bid    <= 4'd0;
      io_axi_mem_bresp  <= OKAY;
      io_axi_mem_rid    <= 4'd0;
      io_axi_mem_rresp  <= OKAY;
      io_axi_mem_rlast  <= 1'b0;
      io_axi_mem_rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_axi_mem_awready) begin
            addr_q         <= io_axi_mem_awaddr;
            len_q          <= io_axi_mem_awlen;
            size_q         <= io_axi_mem_awsize;
            burst_q        <= io_axi_mem_awburst;
            io_axi_mem_bid <= io_axi_mem_awid;
            cnt            <= 8'd0;
            bad_q          <= io_axi_mem_awburst[1] || (io_axi_mem_awatop != 6'd0);
            err_q          <= 1'b0;
            prio_w         <= 1'b0;
            state          <= WRITE;
          end else if (io_axi_mem_arready) begin
            addr_q            <= io_axi_mem_araddr;
            len_q             <= io_axi_mem_arlen;
            size_q            <= io_axi_mem_arsize;
            burst_q           <= io_axi_mem_arburst;
            io_axi_mem_rid    <= io_axi_mem_arid;
            cnt               <= 8'd0;
            bad_q             <= io_axi_mem_arburst[1];
            prio_w            <= 1'b1;
            rerr_q            <= r_bad || !r_ok;
            io_axi_mem_rresp  <= (r_bad || !r_ok) ? SLVERR : OKAY;
            io_axi_mem_rlast  <= (io_axi_mem_arlen == 8'd0);
            io_axi_mem_rvalid <= 1'b1;
            state             <= READ;
          end
        end
        WRITE: begin
          if (io_axi_mem_wvalid) begin
            cnt   <= r_next;
            err_q <= err_q || w_beat_err;
            if (w_final) begin
              io_axi_mem_bresp <= (err_q || w_beat_err) ? SLVERR : OKAY;
              state            <= WRESP;
            end
          end
        end
        WRESP: begin
          if (io_axi_mem_bready) state <= IDLE;
        end
        READ: begin
          if (io_axi_mem_rready) begin
            if (io_axi_mem_rlast) begin
              io_axi_mem_rvalid <= 1'b0;
              state             <= IDLE;
            end else begin
              cnt              <= r_next;
              rerr_q           <= bad_q || !r_ok;
              io_axi_mem_rresp <= (bad_q || !r_ok) ? SLVERR : OKAY;
              io_axi_mem_rlast <= (r_next == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{io_axi_mem_awlock, io_axi_mem_awcache, io_axi_mem_awprot,
                           io_axi_mem_awqos, io_axi_mem_awregion, io_axi_mem_awuser,
                           io_axi_mem_wuser, io_axi_mem_arlock, io_axi_mem_arcache,
                           io_axi_mem_arprot, io_axi_mem_arqos, io_axi_mem_arregion,
                           io_axi_mem_aruser};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: writes, bursts, backpressure, errors, arbitration, reset.
module tb_axi_mem_slave;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  awid;    logic [63:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic [5:0]  awatop; logic awvalid; logic awready;
  logic [63:0] wdata;   logic [7:0]  wstrb;  logic wlast; logic wvalid; logic wready;
  logic [3:0]  bid;     logic [1:0]  bresp;  logic [3:0] buser; logic bvalid; logic bready;
  logic [3:0]  arid;    logic [63:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst; logic arvalid; logic arready;
  logic [3:0]  rid;     logic [63:0] rdata;  logic [1:0] rresp; logic rlast;
  logic [3:0]  ruser;   logic rvalid; logic rready;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_v [4];

  always #5 clk_i = ~clk_i;

  axi_mem_slave dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .io_axi_mem_awid(awid), .io_axi_mem_awaddr(awaddr), .io_axi_mem_awlen(awlen),
    .io_axi_mem_awsize(awsize), .io_axi_mem_awburst(awburst), .io_axi_mem_awlock(1'b0),
    .io_axi_mem_awcache(4'd0), .io_axi_mem_awprot(3'd0), .io_axi_mem_awqos(4'd0),
    .io_axi_mem_awregion(4'd0), .io_axi_mem_awuser(4'd0), .io_axi_mem_awatop(awatop),
    .io_axi_mem_awvalid(awvalid), .io_axi_mem_awready(awready),
    .io_axi_mem_wdata(wdata), .io_axi_mem_wstrb(wstrb), .io_axi_mem_wlast(wlast),
    .io_axi_mem_wuser(4'd0), .io_axi_mem_wvalid(wvalid), .io_axi_mem_wready(wready),
    .io_axi_mem_bid(bid), .io_axi_mem_bresp(bresp), .io_axi_mem_buser(buser),
    .io_axi_mem_bvalid(bvalid), .io_axi_mem_bready(bready),
    .io_axi_mem_arid(arid), .io_axi_mem_araddr(araddr), .io_axi_mem_arlen(arlen),
    .io_axi_mem_arsize(arsize), .io_axi_mem_arburst(arburst), .io_axi_mem_arlock(1'b0),
    .io_axi_mem_arcache(4'd0), .io_axi_mem_arprot(3'd0), .io_axi_mem_arqos(4'd0),
    .io_axi_mem_arregion(4'd0), .io_axi_mem_aruser(4'd0),
    .io_axi_mem_arvalid(arvalid), .io_axi_mem_arready(arready),
    .io_axi_mem_rid(rid), .io_axi_mem_rdata(rdata), .io_axi_mem_rresp(rresp),
    .io_axi_mem_rlast(rlast), .io_axi_mem_ruser(ruser), .io_axi_mem_rvalid(rvalid),
    .io_axi_mem_rready(rready), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_set(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [5:0] atop);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awatop = atop;
    awvalid = 1'b1;
  endtask

  task automatic ar_set(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [5:0] atop);
    bit ok = 1'b0;
    aw_set(id, addr, len, burst, atop);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = awready;
      @(posedge clk_i); #1;
    end
    awvalid = 1'b0;
    chk("aw_handshake", 64'(ok), 64'd1);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    bit ok = 1'b0;
    ar_set(id, addr, len, burst);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = arready;
      @(posedge clk_i); #1;
    end
    arvalid = 1'b0;
    chk("ar_handshake", 64'(ok), 64'd1);
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    bit ok = 1'b0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = wready;
      @(posedge clk_i); #1;
    end
    wvalid = 1'b0;
    chk("w_handshake", 64'(ok), 64'd1);
  endtask

  task automatic b_recv(input string tag, input logic [3:0] id, input logic [1:0] resp);
    bit ok = 1'b0;
    bready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bvalid) begin
        ok = 1'b1;
        chk({tag, "_bid"}, 64'(bid), 64'(id));
        chk({tag, "_bresp"}, 64'(bresp), 64'(resp));
      end
      @(posedge clk_i); #1;
    end
    bready = 1'b0;
    chk({tag, "_bvalid_seen"}, 64'(ok), 64'd1);
  endtask

  // Every R beat in this bench is expected on the very cycle it is asked for.
  task automatic r_recv(input string tag, input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
    bit ok = 1'b0;
    int waited = 0;
    rready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (rvalid) begin
        ok = 1'b1;
        chk({tag, "_rdata"}, rdata, data);
        chk({tag, "_rresp"}, 64'(rresp), 64'(resp));
        chk({tag, "_rlast"}, 64'(rlast), 64'(last));
        chk({tag, "_rid"}, 64'(rid), 64'(id));
      end else begin
        waited++;
      end
      @(posedge clk_i); #1;
    end
    chk({tag, "_rvalid_seen"}, 64'(ok), 64'd1);
    chk({tag, "_latency"}, 64'(waited), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awatop = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
    chk("rst_rid_rresp_rlast", 64'({rid, rresp, rlast}), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Single beat write then read-back
    aw_send(4'd5, 64'h8000_0010, 8'd0, 2'b01, 6'd0);
    w_send(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    b_recv("single_b", 4'd5, 2'b00);
    ar_send(4'd3, 64'h8000_0010, 8'd0, 2'b01);
    r_recv("single_r", 64'h1122_3344_5566_7788, 2'b00, 1'b1, 4'd3);
    chk("single_idle", 64'(dbg_state), 64'd0);

    // INCR len=3, second pass with a partial strobe on beat 2
    aw_send(4'd6, 64'h8000_0100, 8'd3, 2'b01, 6'd0);
    for (int i = 0; i < 4; i++) w_send(64'hAAAA_AAAA_0000_0000 | 64'(i), 8'hFF, i == 3);
    b_recv("incr1_b", 4'd6, 2'b00);
    aw_send(4'd7, 64'h8000_0100, 8'd3, 2'b01, 6'd0);
    for (int i = 0; i < 4; i++)
      w_send(64'hBBBB_BBBB_CCCC_CCC0 | 64'(i), (i == 2) ? 8'h0F : 8'hFF, i == 3);
    b_recv("incr2_b", 4'd7, 2'b00);
    exp_v[0] = 64'hBBBB_BBBB_CCCC_CCC0;
    exp_v[1] = 64'hBBBB_BBBB_CCCC_CCC1;
    exp_v[2] = 64'hAAAA_AAAA_CCCC_CCC2;
    exp_v[3] = 64'hBBBB_BBBB_CCCC_CCC3;
    ar_send(4'd8, 64'h8000_0100, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) r_recv("incr_r", exp_v[i], 2'b00, i == 3, 4'd8);

    // Backpressure: rready low for three cycles after beat 0
    ar_send(4'd9, 64'h8000_0100, 8'd3, 2'b01);
    r_recv("bp_r0", exp_v[0], 2'b00, 1'b0, 4'd9);
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("bp_hold_rvalid", 64'(rvalid), 64'd1);
      chk("bp_hold_rdata", rdata, exp_v[1]);
      chk("bp_hold_rid_rlast", 64'({rid, rlast}), 64'({4'd9, 1'b0}));
    end
    for (int i = 1; i < 4; i++) r_recv("bp_r", exp_v[i], 2'b00, i == 3, 4'd9);

    // WRAP burst is rejected and leaves memory untouched
    aw_send(4'd10, 64'h8000_0010, 8'd0, 2'b10, 6'd0);
    w_send(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
    b_recv("wrap_b", 4'd10, 2'b10);
    ar_send(4'd11, 64'h8000_0010, 8'd0, 2'b01);
    r_recv("wrap_r", 64'h1122_3344_5566_7788, 2'b00, 1'b1, 4'd11);

    // Read straddling the base: beat 0 below memory, beat 1 at word 0
    aw_send(4'd1, 64'h8000_0000, 8'd0, 2'b01, 6'd0);
    w_send(64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b1);
    b_recv("w0_b", 4'd1, 2'b00);
    ar_send(4'd12, 64'h7FFF_FFF8, 8'd1, 2'b01);
    r_recv("low_r0", 64'd0, 2'b10, 1'b0, 4'd12);
    r_recv("low_r1", 64'h0F0E_0D0C_0B0A_0908, 2'b00, 1'b1, 4'd12);

    // Early wlast, atomic op and past-the-end write all report SLVERR
    aw_send(4'd13, 64'h8000_0200, 8'd1, 2'b01, 6'd0);
    w_send(64'h1, 8'hFF, 1'b1);
    w_send(64'h2, 8'hFF, 1'b1);
    b_recv("wlast_b", 4'd13, 2'b10);
    aw_send(4'd14, 64'h8000_0010, 8'd0, 2'b01, 6'h20);
    w_send(64'h3, 8'hFF, 1'b1);
    b_recv("atop_b", 4'd14, 2'b10);
    aw_send(4'd15, 64'h8008_0000, 8'd0, 2'b01, 6'd0);
    w_send(64'h4, 8'hFF, 1'b1);
    b_recv("oor_b", 4'd15, 2'b10);
    ar_send(4'd2, 64'h8000_0010, 8'd0, 2'b01);
    r_recv("atop_mem_r", 64'h1122_3344_5566_7788, 2'b00, 1'b1, 4'd2);

    // Reset in the middle of a read burst
    ar_send(4'd4, 64'h8000_0100, 8'd3, 2'b01);
    r_recv("rstmid_r0", exp_v[0], 2'b00, 1'b0, 4'd4);
    rready = 1'b0;
    rst_i  = 1'b1;
    @(posedge clk_i); #1;
    chk("rstmid_rvalid", 64'(rvalid), 64'd0);
    chk("rstmid_state", 64'(dbg_state), 64'd0);
    rst_i = 1'b0;
    ar_send(4'd6, 64'h8000_0100, 8'd0, 2'b01);
    r_recv("post_rst_r", exp_v[0], 2'b00, 1'b1, 4'd6);

    // Collisions: write wins first, then the pending read wins against a new write
    aw_set(4'd1, 64'h8000_0300, 8'd0, 2'b01, 6'd0);
    ar_set(4'd2, 64'h8000_0300, 8'd0, 2'b01);
    #1;
    chk("col1_awready", 64'(awready), 64'd1);
    chk("col1_arready", 64'(arready), 64'd0);
    @(posedge clk_i); #1;
    awvalid = 1'b0;
    w_send(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    b_recv("col1_b", 4'd1, 2'b00);
    aw_set(4'd3, 64'h8000_0308, 8'd0, 2'b01, 6'd0);
    #1;
    chk("col2_arready", 64'(arready), 64'd1);
    chk("col2_awready", 64'(awready), 64'd0);
    @(posedge clk_i); #1;
    arvalid = 1'b0;
    r_recv("col2_r", 64'h5555_6666_7777_8888, 2'b00, 1'b1, 4'd2);
    #1;
    chk("col2_aw_after", 64'(awready), 64'd1);
    @(posedge clk_i); #1;
    awvalid = 1'b0;
    w_send(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1);
    b_recv("col2_b", 4'd3, 2'b00);
    chk("final_idle", 64'(dbg_state), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 slave memory that consumes the core's flat `io_axi_mem_*` AXI master bus; it sits directly downstream of the core top level.
- Backing store is a single-port, synchronous-read word SRAM that serves one transaction at a time.
- Supports FIXED and INCR bursts, byte strobes, and SLVERR reporting for unsupported or out-of-range accesses.
- Used as boot/DRAM model in simulation and as on-chip scratch memory in FPGA builds.

Parameters:
- DEPTH, 65536, number of 64-bit words; must be a power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- io_axi_mem_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user,atop}  in  4/64/8/3/2/1/4/3/4/4/4/6  AW payload.
- io_axi_mem_awvalid  in  1.
- io_axi_mem_awready  out  1.
- io_axi_mem_w{data,strb,last,user}  in  64/8/1/4  W payload.
- io_axi_mem_wvalid  in  1.
- io_axi_mem_wready  out  1.
- io_axi_mem_b{id,resp,user}  out  4/2/4  B payload.
- io_axi_mem_bvalid  out  1.
- io_axi_mem_bready  in  1.
- io_axi_mem_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  4/64/8/3/2/1/4/3/4/4/4  AR payload.
- io_axi_mem_arvalid  in  1.
- io_axi_mem_arready  out  1.
- io_axi_mem_r{id,data,resp,last,user}  out  4/64/2/1/4  R payload.
- io_axi_mem_rvalid  out  1.
- io_axi_mem_rready  in  1.

Behaviour:
- FSM states: IDLE, WRITE, WRESP, READ.
- Reset: state=IDLE, all ready/valid=0, bid/bresp/rid/rdata/rresp/rlast=0, prio=WRITE. SRAM contents are not cleared. Reset mid-burst abandons the transaction immediately.
- Arbitration (IDLE only):
  - grant_w = awvalid & (!arvalid | prio==WRITE); grant_r = arvalid & !grant_w.
  - awready = IDLE & grant_w; arready = IDLE & grant_r. Never both high.
  - prio flips to the other channel after each grant.
- Beat address:
  - beat i addr = addr + i*(1<<size) for INCR, addr for FIXED.
  - word index = (beat addr - BASE_ADDR) >> 3.
  - A beat is in range iff beat addr >= BASE_ADDR and index < DEPTH.
  - Arithmetic is 64-bit. Wrap past 2^64 counts as out of range.
- Error classes:
  - burst==WRAP (2'b10) or reserved (2'b11): every beat is an error.
  - awatop!=0: every beat is an error.
  - Out-of-range beat: error for that beat only.
  - Error beats never touch the SRAM.
- Write path:
  - AW handshake latches id, addr, len, size, burst; beat counter=0; clears err flag; goes to WRITE.
  - WRITE: wready=1. Each W handshake writes wdata under wstrb to the SRAM the same cycle (if no error) and increments the counter.
  - On beat len: wready drops next cycle; go to WRESP.
  - wlast is ignored for termination. wlast asserted on a non-final beat, or deasserted on the final beat, sets err.
  - WRESP: bvalid=1, bid=latched id, bresp=SLVERR(2'b10) if any beat erred else OKAY, buser=0. Held until bready, then IDLE.
- Read path:
  - AR handshake latches id, addr, len, size, burst; issues the SRAM read of beat 0 in the same cycle; goes to READ.
  - Next cycle: rvalid=1, rdata = SRAM output (0 on error beat), rresp per beat, rid=latched id, rlast = (beat==len), ruser=0.
  - On R handshake with beats remaining: next beat's read is issued in the same cycle, giving 1 beat/cycle at sustained rready.
  - rvalid && !rready holds all R outputs stable.
  - Handshake with rlast=1: IDLE next cycle, rvalid=0.
- len=0 is a single beat. len=255 gives 256 beats; the counter is 8 bits and never wraps within a burst.
- AxLOCK, cache, prot, qos, region, user are ignored. Exclusive accesses get OKAY.

Test Plan:
- Single write then read: AW addr=0x8000_0010 len=0, W data=0x1122334455667788 strb=0xFF → B OKAY, bid echoed. AR same addr → one R beat with that data, rlast=1, OKAY, rvalid one cycle after arready.
- INCR len=3 write with strb=0x0F on beat 2, rready held high → 4 back-to-back R beats on consecutive cycles. Beat 2 upper 4 bytes keep their old value.
- R backpressure: rready low for 3 cycles mid-burst → rdata/rid/rlast stable, no beat lost or duplicated.
- Errors:
  - WRAP write → B SLVERR, memory unchanged.
  - AR at 0x7FFF_FFF8 len=1 → beat 0 SLVERR with data 0, beat 1 (0x8000_0000) OKAY.
  - wlast early on beat 0 of len=1 → SLVERR.
- Simultaneous awvalid and arvalid after reset → write granted first, read next. Repeat the collision → read granted first.
- rst_i asserted mid read burst → next cycle rvalid=0, state IDLE. A subsequent read returns data written before the reset.
